// File: rtl/seq_alu_pkg.sv
// Shared types and constants for the sequential ALU core.
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_XOR    = 4'd4,
        OP_SHL    = 4'd5,
        OP_SHR    = 4'd6,
        OP_MUL    = 4'd7,
        OP_PASS_B = 4'd8,
        OP_DIV    = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_E = 4;

    function automatic logic [4:0] pack_flags(logic e, logic v, logic c, logic n, logic z);
        logic [4:0] f;
        f         = '0;
        f[FLAG_E] = e;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/seq_alu_core_if.sv
// Operand/result handshake bundle between a requester and seq_alu_core.
interface seq_alu_core_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             acc_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic [4:0]       flags;
    logic             busy;

    modport master (
        output in_valid, op, a, b, acc_sel, out_ready,
        input  in_ready, out_valid, result, result_hi, flags, busy
    );

    modport slave (
        input  in_valid, op, a, b, acc_sel, out_ready,
        output in_ready, out_valid, result, result_hi, flags, busy
    );
endinterface

// File: rtl/seq_alu_iter.sv
// Iterative shift-add multiplier, one bit per cycle for WIDTH cycles.
// Define ALU_DIV_EN to add the restoring divider on the same registers.
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] hi_q, lo_q, b_q;
    logic [CW-1:0]    cnt;
    logic             running;
    logic             load;
    logic [WIDTH:0]   sum;
`ifdef ALU_DIV_EN
    logic             mode_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;
`endif

    // hi/lo present the value after the step taken this cycle, so the core
    // can capture the final product on the same edge that ends EXEC.
    always_comb begin
        sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        hi  = sum[WIDTH:1];
        lo  = {sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        load    = start;
        shifted = {hi_q, lo_q[WIDTH-1]};
        ge      = shifted >= {1'b0, b_q};
        diff    = shifted[WIDTH-1:0] - b_q;
        if (mode_q) begin
            hi = ge ? diff : shifted[WIDTH-1:0];
            lo = {lo_q[WIDTH-2:0], ge};
        end
`else
        load = start && !mode;
`endif
    end

    assign done = running && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
`ifdef ALU_DIV_EN
            mode_q  <= 1'b0;
`endif
        end else if (load) begin
            running <= 1'b1;
            cnt     <= CW'(WIDTH - 1);
            hi_q    <= '0;
            lo_q    <= a;
            b_q     <= b;
`ifdef ALU_DIV_EN
            mode_q  <= mode;
`endif
        end else if (running) begin
            hi_q <= hi;
            lo_q <= lo;
            if (cnt == '0) running <= 1'b0;
            else           cnt     <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/seq_alu_core.sv
// Multi-cycle ALU core with valid/ready handshakes, accumulator and flags.
// Define ALU_DIV_EN to make opcode 9 an unsigned divide instead of illegal.
module seq_alu_core
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_alu_core_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    state_e           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opa;
    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v, sc_e;
    logic [4:0]       sc_flags, mc_flags;
    logic             accept, multi, is_div;
    logic             mc_c, mc_v;
    logic [WIDTH-1:0] it_hi, it_lo;
    logic             it_done;
`ifdef ALU_DIV_EN
    logic             div_q, bzero_q;
`endif

    assign bus.in_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);

    always_comb begin
        opa    = bus.acc_sel ? acc : bus.a;
        sh     = bus.b[SHW-1:0];
        accept = (state == IDLE) && bus.in_valid;
        is_div = (bus.op == OP_DIV);
`ifdef ALU_DIV_EN
        multi  = (bus.op == OP_MUL) || is_div;
`else
        multi  = (bus.op == OP_MUL);
`endif
        wide   = '0;
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_e   = 1'b0;
        case (bus.op)
            OP_ADD: begin
                wide   = {1'b0, opa} + {1'b0, bus.b};
                sc_res = wide[WIDTH-1:0];
                sc_c   = wide[WIDTH];
                sc_v   = (opa[MSB] == bus.b[MSB]) && (sc_res[MSB] != opa[MSB]);
            end
            OP_SUB: begin
                wide   = {1'b0, opa} - {1'b0, bus.b};
                sc_res = wide[WIDTH-1:0];
                sc_c   = wide[WIDTH];
                sc_v   = (opa[MSB] != bus.b[MSB]) && (sc_res[MSB] != opa[MSB]);
            end
            OP_AND: sc_res = opa & bus.b;
            OP_OR:  sc_res = opa | bus.b;
            OP_XOR: sc_res = opa ^ bus.b;
            // The extra bit beside the operand catches the last bit shifted out.
            OP_SHL: begin
                wide   = {1'b0, opa} << sh;
                sc_res = wide[WIDTH-1:0];
                sc_c   = wide[WIDTH];
            end
            OP_SHR: begin
                wide   = {opa, 1'b0} >> sh;
                sc_res = wide[WIDTH:1];
                sc_c   = wide[0];
            end
            OP_PASS_B: sc_res = bus.b;
            OP_MUL: ;
`ifdef ALU_DIV_EN
            OP_DIV: ;
`endif
            default: sc_e = 1'b1;
        endcase
        sc_flags = sc_e ? pack_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b0)
                        : pack_flags(1'b0, sc_v, sc_c, sc_res[MSB], sc_res == '0);
`ifdef ALU_DIV_EN
        mc_c = div_q ? 1'b0 : (it_hi != '0);
        mc_v = div_q && bzero_q;
`else
        mc_c = (it_hi != '0);
        mc_v = 1'b0;
`endif
        mc_flags = pack_flags(1'b0, mc_v, mc_c, it_lo[MSB], it_lo == '0);
    end

    seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk   (clk),
        .rst   (rst),
        .start (accept && multi),
        .mode  (is_div),
        .a     (opa),
        .b     (bus.b),
        .hi    (it_hi),
        .lo    (it_lo),
        .done  (it_done)
    );

    // Results are registered on DONE entry and held until the consumer takes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            acc           <= '0;
            bus.result    <= '0;
            bus.result_hi <= '0;
            bus.flags     <= '0;
            bus.out_valid <= 1'b0;
`ifdef ALU_DIV_EN
            div_q         <= 1'b0;
            bzero_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept && multi) begin
                        state <= EXEC;
`ifdef ALU_DIV_EN
                        div_q   <= is_div;
                        bzero_q <= (bus.b == '0);
`endif
                    end else if (accept) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.result    <= sc_res;
                        bus.result_hi <= '0;
                        bus.flags     <= sc_flags;
                        if (!sc_e) acc <= sc_res;
                    end
                end
                EXEC: begin
                    if (it_done) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.result    <= it_lo;
                        bus.result_hi <= it_hi;
                        bus.flags     <= mc_flags;
                        acc           <= it_lo;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu_core.sv
// Scoreboard bench for seq_alu_core (WIDTH=8): directed cases plus random
// operations checked against an arithmetic reference model.
module tb_seq_alu_core;
    localparam int W = 8;

    typedef struct {
        int res;
        int hi;
        int flg;
        int lat;
        int acc_cyc;
        int hold;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    int   model_acc;
    exp_t sb[$];

    seq_alu_core_if #(.WIDTH(W)) bus ();

    seq_alu_core #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int s8(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    // Reference model: plain integer arithmetic on the operand values.
    function automatic exp_t model(input int op, input int a, input int b);
        exp_t e;
        int   r, h, s, sv;
        bit   c, v, err;
        r = 0; h = 0; c = 0; v = 0; err = 0;
        e.lat = 1;
        case (op)
            0: begin r = a + b; c = (r > 255); sv = s8(a) + s8(b); v = (sv > 127) || (sv < -128); end
            1: begin r = a - b; c = (a < b);   sv = s8(a) - s8(b); v = (sv > 127) || (sv < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin s = b % W; r = a << s; c = (s != 0) && (((a << s) >> W) % 2 == 1); end
            6: begin s = b % W; r = a >> s; c = (s != 0) && (((a >> (s - 1)) % 2) == 1); end
            7: begin r = a * b; h = r / 256; c = (h != 0); e.lat = W + 1; end
            8: r = b;
`ifdef ALU_DIV_EN
            9: begin
                if (b == 0) begin r = 255; h = a; v = 1; end
                else begin r = a / b; h = a % b; end
                e.lat = W + 1;
            end
`endif
            default: err = 1;
        endcase
        r = r & 255;
        e.res = r;
        e.hi  = h & 255;
        if (err) e.flg = 16;
        else e.flg = (int'(v) << 3) | (int'(c) << 2) | ((r >= 128) ? 2 : 0) | ((r == 0) ? 1 : 0);
        return e;
    endfunction

    task automatic applyStimulus(input int op, input int a, input int b, input bit acc_sel,
                                 input int hold, input bit push);
        exp_t e;
        int   opa;
        int   guard;
        int   start_cyc;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = op[3:0];
        bus.a        = a[W-1:0];
        bus.b        = b[W-1:0];
        bus.acc_sel  = acc_sel;
        guard = 0;
        while (!bus.in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            checkOutput("in_ready_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        start_cyc = cyc;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.acc_sel  = 1'($urandom);
        if (push) begin
            opa       = acc_sel ? model_acc : a;
            e         = model(op, opa, b);
            e.acc_cyc = start_cyc;
            e.hold    = hold;
            if (e.flg != 16) model_acc = e.res;
            sb.push_back(e);
        end
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || bus.out_valid || !bus.in_ready) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) checkOutput("idle_timeout", 0, 1);
    endtask

    // Monitor: compares every presented result against the head of the scoreboard.
    initial begin : monitor
        exp_t cur;
        bit   seen;
        bit   post;
        int   hold;
        seen = 0;
        post = 0;
        hold = 0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_out_valid", 1, 0);
                    bus.out_ready = 1'b1;
                end else begin
                    cur = sb[0];
                    if (!seen) begin
                        seen = 1;
                        hold = cur.hold;
                        checkOutput("latency", cyc - cur.acc_cyc, cur.lat);
                    end
                    checkOutput("result", int'(bus.result), cur.res);
                    checkOutput("result_hi", int'(bus.result_hi), cur.hi);
                    checkOutput("flags", int'(bus.flags), cur.flg);
                    checkOutput("in_ready_while_done", int'(bus.in_ready), 0);
                    checkOutput("busy_while_done", int'(bus.busy), 1);
                    if (hold > 0) begin
                        hold--;
                        bus.out_ready = 1'b0;
                    end else begin
                        bus.out_ready = 1'b1;
                        void'(sb.pop_front());
                        seen = 0;
                        post = 1;
                    end
                end
            end else begin
                bus.out_ready = 1'($urandom);
                if (post && !rst) checkOutput("in_ready_after_handshake", int'(bus.in_ready), 1);
                post = 0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        int op, a, b, hold;
        bit sel;
        cyc          = 0;
        checks       = 0;
        errors       = 0;
        model_acc    = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.op       = '0;
        bus.a        = '0;
        bus.b        = '0;
        bus.acc_sel  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", int'(bus.out_valid), 0);
        checkOutput("reset_result", int'(bus.result), 0);
        checkOutput("reset_result_hi", int'(bus.result_hi), 0);
        checkOutput("reset_flags", int'(bus.flags), 0);
        checkOutput("reset_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_reset", int'(bus.in_ready), 1);

        $display("[TB] directed arithmetic");
        applyStimulus(0, 200, 100, 0, 0, 1);
        applyStimulus(1, 'h80, 1, 0, 0, 1);
        applyStimulus(1, 3, 5, 0, 0, 1);
        applyStimulus(7, 15, 17, 0, 0, 1);
        applyStimulus(7, 'hFF, 'hFF, 0, 0, 1);
        applyStimulus(0, 1, 1, 0, 3, 1);
        applyStimulus(5, 'h81, 0, 0, 0, 1);
        applyStimulus(6, 'h81, 7, 0, 1, 1);

        $display("[TB] accumulator chain");
        applyStimulus(8, 0, 10, 0, 0, 1);
        applyStimulus(0, 0, 5, 1, 0, 1);
        applyStimulus(5, 0, 1, 1, 0, 1);
        applyStimulus(12, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 1);
        applyStimulus(9, 100, 7, 0, 0, 1);
        applyStimulus(9, 9, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 1);

        $display("[TB] reset during multiply");
        waitIdle();
        applyStimulus(7, 'h5A, 'h33, 0, 0, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_out_valid", int'(bus.out_valid), 0);
        checkOutput("abort_in_ready", int'(bus.in_ready), 1);
        checkOutput("abort_busy", int'(bus.busy), 0);
        model_acc = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        applyStimulus(0, 0, 7, 1, 0, 1);

        $display("[TB] random operations");
        for (int i = 0; i < 80; i++) begin
            op   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
            a    = $urandom_range(0, 255);
            b    = $urandom_range(0, 255);
            sel  = 1'($urandom);
            hold = $urandom_range(0, 2);
            applyStimulus(op, a, b, sel, hold, 1);
        end

        waitIdle();
        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
